// File: rtl/prbs_pkg.sv
// Shared constants for the PRBS checker and the Galois auto-LFSR generator it follows:
// default polynomial and the checker FSM state encoding.
package prbs_pkg;

    localparam int PRBS_LENGTH = 8;
    localparam logic [PRBS_LENGTH:1] PRBS_TAPS = 8'b1100_1111;

    typedef logic [1:0] prbs_state_t;

    localparam prbs_state_t HUNT   = 2'd0;
    localparam prbs_state_t VERIFY = 2'd1;
    localparam prbs_state_t LOCKED = 2'd2;

endpackage

// File: rtl/galois_next.sv
// Combinational Galois LFSR step: bit 1 takes the feedback bit, tapped bits XOR it in.
// Shared by the generator and both prediction paths of the checker.
module galois_next
    import prbs_pkg::*;
#(
    parameter int                LENGTH = PRBS_LENGTH,
    parameter logic [LENGTH:1]   TAPS   = PRBS_TAPS
) (
    input  logic [LENGTH:1] y_i,
    output logic [LENGTH:1] n_o
);

    assign n_o[1] = y_i[LENGTH];

    // TAPS is indexed mirror-wise: the tap for bit i lives at TAPS[LENGTH+1-i].
    for (genvar i = 2; i <= LENGTH; i++) begin : g_bit
        assign n_o[i] = TAPS[LENGTH+1-i] ? (y_i[i-1] ^ y_i[LENGTH]) : y_i[i-1];
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS word checker: HUNT -> VERIFY -> LOCKED, saturating word-error count.
// Define PRBS_CHECKER_BITERR_EN to add a saturating bit-error counter output (bit_err_cnt).
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int              LENGTH     = PRBS_LENGTH,
    parameter logic [LENGTH:1] TAPS       = PRBS_TAPS,
    parameter int              LOCK_CNT   = 4,
    parameter int              UNLOCK_CNT = 3,
    parameter int              CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [LENGTH:1]   din,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_cnt,
`ifdef PRBS_CHECKER_BITERR_EN
    output logic [CNT_W-1:0]  bit_err_cnt,
`endif
    output logic [1:0]        state
);

    localparam logic [3:0]       LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0]       UNLOCK_N = 4'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    prbs_state_t       state_q, state_d;
    logic [LENGTH:1]   e_q, e_d;
    logic [3:0]        match_q, match_d;
    logic [3:0]        miss_q, miss_d;
    logic              err_pulse_q, err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [LENGTH:1]   step_din, step_e;
    logic              din_match;
    logic              din_zero;

    galois_next #(.LENGTH(LENGTH), .TAPS(TAPS)) u_step_din (
        .y_i (din),
        .n_o (step_din)
    );

    galois_next #(.LENGTH(LENGTH), .TAPS(TAPS)) u_step_e (
        .y_i (e_q),
        .n_o (step_e)
    );

    assign din_match = (din == e_q);
    assign din_zero  = (din == '0);

    always_comb begin
        // NOTE: every next-state signal is defaulted to its hold value first, so no path can infer a latch.
        state_d = state_q;
        e_d     = e_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (!din_zero) begin
                        e_d     = step_din;
                        match_d = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    e_d = step_din;
                    if (din_match) begin
                        match_d = match_q + 4'd1;
                        if (match_d == LOCK_N) state_d = LOCKED;
                    end else begin
                        match_d = '0;
                        if (din_zero) state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (din_match) begin
                        e_d    = step_din;
                        miss_d = '0;
                    end else begin
                        // Flywheel on the local prediction; corrupted data never reseeds.
                        e_d    = step_e;
                        err_d  = 1'b1;
                        miss_d = miss_q + 4'd1;
                        if (miss_d == UNLOCK_N) begin
                            miss_d  = '0;
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (err_d && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= HUNT;
            e_q         <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            e_q         <= e_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

`ifdef PRBS_CHECKER_BITERR_EN
    localparam int POP_W = $clog2(LENGTH + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    logic [CNT_W-1:0] bit_err_cnt_q, bit_err_cnt_d;
    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] bit_sum;

    always_comb begin
        pop           = POP_W'($countones(din ^ e_q));
        bit_sum       = SUM_W'(bit_err_cnt_q) + SUM_W'(pop);
        bit_err_cnt_d = bit_err_cnt_q;
        if (clr_cnt) begin
            bit_err_cnt_d = '0;
        end else if (err_d) begin
            bit_err_cnt_d = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(bit_sum);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_err_cnt_q <= '0;
        end else begin
            bit_err_cnt_q <= bit_err_cnt_d;
        end
    end

    assign bit_err_cnt = bit_err_cnt_q;
`endif

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: vector table, corner sequences and a random stream against a word-level model.
// A second instance with CNT_W = 2 shares the stimulus to exercise counter saturation.
`timescale 1ns/1ps
module tb_prbs_checker;
    import prbs_pkg::*;

    localparam int LOCK_N   = 4;
    localparam int UNLOCK_N = 3;
    localparam int MAX_W    = 65535;
    localparam int MAX_S    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        locked, err_pulse, locked_s, err_pulse_s;
    logic [15:0] err_cnt;
    logic [1:0]  err_cnt_s;
    logic [1:0]  state, state_s;
`ifdef PRBS_CHECKER_BITERR_EN
    logic [15:0] bit_err_cnt;
    logic [1:0]  bit_err_cnt_s;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .clr_cnt    (clr_cnt),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt),
`ifdef PRBS_CHECKER_BITERR_EN
        .bit_err_cnt(bit_err_cnt),
`endif
        .state      (state)
    );

    prbs_checker #(.CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .clr_cnt    (clr_cnt),
        .locked     (locked_s),
        .err_pulse  (err_pulse_s),
        .err_cnt    (err_cnt_s),
`ifdef PRBS_CHECKER_BITERR_EN
        .bit_err_cnt(bit_err_cnt_s),
`endif
        .state      (state_s)
    );

    // Galois step as shift-left plus conditional XOR with the feedback mask.
    logic [7:0] fb_mask;

    function automatic logic [7:0] nxt(input logic [7:0] y);
        return {y[6:0], 1'b0} ^ (y[7] ? fb_mask : 8'h00);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Word-level reference model.
    int         m_state, m_match, m_miss, m_cnt, m_cnt_s, m_bit, m_bit_s;
    logic [7:0] m_e;
    bit         m_pulse;

    task automatic model_reset();
        m_state = 0; m_match = 0; m_miss = 0; m_e = 8'h00; m_pulse = 0;
        m_cnt = 0; m_cnt_s = 0; m_bit = 0; m_bit_s = 0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit clr);
        bit err;
        int pop;
        err = 0;
        pop = 0;
        if (v) begin
            if (m_state == 0) begin
                if (d != 8'h00) begin
                    m_e = nxt(d); m_match = 0; m_state = 1;
                end
            end else if (m_state == 1) begin
                if (d == m_e) begin
                    m_match++;
                    if (m_match == LOCK_N) m_state = 2;
                end else begin
                    m_match = 0;
                    if (d == 8'h00) m_state = 0;
                end
                m_e = nxt(d);
            end else begin
                if (d == m_e) begin
                    m_miss = 0; m_e = nxt(d);
                end else begin
                    err = 1;
                    pop = $countones(d ^ m_e);
                    m_e = nxt(m_e);
                    m_miss++;
                    if (m_miss == UNLOCK_N) begin
                        m_miss = 0; m_state = 0;
                    end
                end
            end
        end
        m_pulse = err;
        if (clr) begin
            m_cnt = 0; m_cnt_s = 0; m_bit = 0; m_bit_s = 0;
        end else if (err) begin
            m_cnt   = imin(m_cnt + 1, MAX_W);
            m_cnt_s = imin(m_cnt_s + 1, MAX_S);
            m_bit   = imin(m_bit + pop, MAX_W);
            m_bit_s = imin(m_bit_s + pop, MAX_S);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " state"},     32'(state),       32'(m_state));
        check({tag, " locked"},    32'(locked),      32'(m_state == 2));
        check({tag, " err_pulse"}, 32'(err_pulse),   32'(m_pulse));
        check({tag, " err_cnt"},   32'(err_cnt),     32'(m_cnt));
        check({tag, " sat state"}, 32'(state_s),     32'(m_state));
        check({tag, " sat pulse"}, 32'(err_pulse_s), 32'(m_pulse));
        check({tag, " sat cnt"},   32'(err_cnt_s),   32'(m_cnt_s));
`ifdef PRBS_CHECKER_BITERR_EN
        check({tag, " bit_err"},     32'(bit_err_cnt),   32'(m_bit));
        check({tag, " sat bit_err"}, 32'(bit_err_cnt_s), 32'(m_bit_s));
`endif
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled there too.
    task automatic cycle(input bit v, input logic [7:0] d, input bit clr);
        din_valid = v;
        din       = d;
        clr_cnt   = clr;
        @(posedge clk);
        model_edge(v, d, clr);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst       = 1'b1;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        #2;
        model_reset();
        check_model(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] g;

    task automatic send(input logic [7:0] flip, input bit clr);
        cycle(1'b1, g ^ flip, clr);
        g = nxt(g);
    endtask

    typedef struct {
        bit         v;
        int         idx;
        logic [7:0] flip;
        bit         clr;
        logic [1:0] st;
        bit         pulse;
        int         cnt;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] seq [0:31];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] taps;
        logic [7:0] flip;
        logic [7:0] d;
        bit         v;
        bit         clr;

        taps = PRBS_TAPS;
        fb_mask[0] = 1'b1;
        for (int k = 1; k < 8; k++) fb_mask[k] = taps[7-k];

        seq[0] = 8'h91;
        for (int k = 1; k < 32; k++) seq[k] = nxt(seq[k-1]);

        // Lock, single error, clear, three-error unlock, relock, misses broken by a good word.
        tbl.push_back('{1, 0,  8'h00, 0, VERIFY, 0, 0});
        tbl.push_back('{1, 1,  8'h00, 0, VERIFY, 0, 0});
        tbl.push_back('{1, 2,  8'h00, 0, VERIFY, 0, 0});
        tbl.push_back('{1, 3,  8'h00, 0, VERIFY, 0, 0});
        tbl.push_back('{1, 4,  8'h00, 0, LOCKED, 0, 0});
        tbl.push_back('{0, 5,  8'h00, 0, LOCKED, 0, 0});
        tbl.push_back('{1, 5,  8'h00, 0, LOCKED, 0, 0});
        tbl.push_back('{1, 6,  8'h01, 0, LOCKED, 1, 1});
        tbl.push_back('{1, 7,  8'h00, 0, LOCKED, 0, 1});
        tbl.push_back('{1, 8,  8'h00, 1, LOCKED, 0, 0});
        tbl.push_back('{1, 9,  8'hFF, 0, LOCKED, 1, 1});
        tbl.push_back('{0, 9,  8'h00, 0, LOCKED, 0, 1});
        tbl.push_back('{1, 10, 8'h80, 0, LOCKED, 1, 2});
        tbl.push_back('{1, 11, 8'h10, 0, HUNT,   1, 3});
        tbl.push_back('{1, 12, 8'h00, 0, VERIFY, 0, 3});
        tbl.push_back('{1, 13, 8'h00, 0, VERIFY, 0, 3});
        tbl.push_back('{1, 14, 8'h00, 0, VERIFY, 0, 3});
        tbl.push_back('{1, 15, 8'h00, 0, VERIFY, 0, 3});
        tbl.push_back('{1, 16, 8'h00, 0, LOCKED, 0, 3});
        tbl.push_back('{1, 17, 8'h00, 1, LOCKED, 0, 0});
        tbl.push_back('{1, 18, 8'h02, 0, LOCKED, 1, 1});
        tbl.push_back('{1, 19, 8'h00, 0, LOCKED, 0, 1});
        tbl.push_back('{1, 20, 8'h04, 0, LOCKED, 1, 2});
        tbl.push_back('{1, 21, 8'h08, 0, LOCKED, 1, 3});
        tbl.push_back('{1, 22, 8'h00, 0, LOCKED, 0, 3});

        do_reset("reset");
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].v, seq[tbl[i].idx] ^ tbl[i].flip, tbl[i].clr);
            check($sformatf("vec%0d state", i),   32'(state),     32'(tbl[i].st));
            check($sformatf("vec%0d locked", i),  32'(locked),    32'(tbl[i].st == LOCKED));
            check($sformatf("vec%0d pulse", i),   32'(err_pulse), 32'(tbl[i].pulse));
            check($sformatf("vec%0d cnt", i),     32'(err_cnt),   32'(tbl[i].cnt));
            check($sformatf("vec%0d sat cnt", i), 32'(err_cnt_s), 32'(imin(tbl[i].cnt, MAX_S)));
        end

        // All-zero words never leave HUNT; a zero word in VERIFY drops back to HUNT.
        do_reset("reset zero");
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 8'h00, 1'b0);
            check("zero hunt state", 32'(state), 32'(HUNT));
            check("zero hunt pulse", 32'(err_pulse), 32'd0);
        end
        cycle(1'b1, 8'h91, 1'b0);
        check("zero seed state", 32'(state), 32'(VERIFY));
        cycle(1'b1, 8'h00, 1'b0);
        check("zero verify state", 32'(state), 32'(HUNT));
        check("zero verify pulse", 32'(err_pulse), 32'd0);

        // Saturation of the 2-bit counter, then clear colliding with an error.
        do_reset("reset sat");
        g = 8'h91;
        for (int i = 0; i < 5; i++) send(8'h00, 1'b0);
        check("sat locked", 32'(locked_s), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            send(8'h01, 1'b0);
            check($sformatf("sat err%0d pulse", k), 32'(err_pulse_s), 32'd1);
            check($sformatf("sat err%0d cnt", k),   32'(err_cnt_s),   32'(imin(k, MAX_S)));
            check($sformatf("sat err%0d wide", k),  32'(err_cnt),     32'(k));
            send(8'h00, 1'b0);
            check($sformatf("sat good%0d pulse", k), 32'(err_pulse_s), 32'd0);
        end
        send(8'h01, 1'b1);
        check("clr+err cnt",    32'(err_cnt_s),   32'd0);
        check("clr+err wide",   32'(err_cnt),     32'd0);
        check("clr+err pulse",  32'(err_pulse_s), 32'd1);
        check("clr+err locked", 32'(locked),      32'd1);

`ifdef PRBS_CHECKER_BITERR_EN
        do_reset("reset biterr");
        g = 8'h91;
        for (int i = 0; i < 5; i++) send(8'h00, 1'b0);
        send(8'h07, 1'b0);
        check("biterr bits",  32'(bit_err_cnt), 32'd3);
        check("biterr words", 32'(err_cnt),     32'd1);
`endif

        // Random stream: gaps, corruption, slips, zero words, clears and mid-run resets.
        do_reset("reset rnd");
        g = 8'h91;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset("rnd reset");
                continue;
            end
            v    = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 99) == 0);
            flip = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            if ($urandom_range(0, 199) == 0) g = 8'($urandom_range(1, 255));
            d = ($urandom_range(0, 149) == 0) ? 8'h00 : (g ^ flip);
            cycle(v, d, clr);
            if (v) g = nxt(g);
            check_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
